// File: rtl/sar_out_pkg.sv
// Shared widths and the sample word type for the SAR output capture path.
// Optional SAR_OUT_DROP_CNT_EN enables the dropped-word counter in the top.
package sar_out_pkg;

    localparam int SAR_DATA_W = 9;
    localparam int DROP_CNT_W = 8;

    typedef logic [SAR_DATA_W-1:0] sample_t;

endpackage

// File: rtl/sar_out_fifo.sv
// Synchronous FIFO with registered occupancy; head entry always visible.
// A pop on a full FIFO frees the slot the simultaneous push lands in.
module sar_out_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [PW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   lvl_q, lvl_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (lvl_q == '0);
    assign full    = (lvl_q == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_q];
    assign level   = lvl_q;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

endmodule

// File: rtl/sar_out_capture.sv
// Resynchronises the SAR done strobe, averages 2^AVG_LOG2 results and queues them.
// Define SAR_OUT_DROP_CNT_EN to build the saturating dropped-word counter.
module sar_out_capture
    import sar_out_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          EN,
    input  logic                          CKO,
    input  logic [0:8]                    DATA,
    output logic [8:0]                    OUT_DATA,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
    output logic                          OVF,
    input  logic                          CLR_OVF,
    output logic [DROP_CNT_W-1:0]         DROP_CNT
);

    localparam int ACC_W = SAR_DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;

    logic                   cap;
    logic                   cnt_last;
    logic [ACC_W-1:0]       acc_sum;
    sample_t                sample;
    sample_t                word;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], CKO};
    assign hist_d = sync_q[SYNC_STAGES-1];
    assign cap    = sync_q[SYNC_STAGES-1] & ~hist_q & EN;

    // DATA[0] is the MSB, so the plain vector value is the sample value.
    assign sample   = DATA;
    assign acc_sum  = acc_q + ACC_W'(sample);
    assign word     = sample_t'(acc_sum >> AVG_LOG2);
    assign cnt_last = (AVG_LOG2 == 0) || (&cnt_q);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        if (!EN) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (cap) begin
            if (cnt_last) begin
                push  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    sar_out_fifo #(
        .W     (SAR_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .pop   (pop),
        .din   (word),
        .dout  (OUT_DATA),
        .level (LEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign OUT_VALID = ~fifo_empty;
    assign pop       = OUT_VALID & OUT_READY;
    assign drop      = push & fifo_full & ~pop;

    // Set beats clear when a drop coincides with CLR_OVF.
    always_comb begin
        ovf_d = ovf_q;
        if (CLR_OVF) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    assign OVF = ovf_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef SAR_OUT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (CLR_OVF) drop_cnt_d = '0;
        if (drop && (drop_cnt_d != '1)) drop_cnt_d = drop_cnt_d + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign DROP_CNT = drop_cnt_q;
`else
    assign DROP_CNT = '0;
`endif

endmodule

// File: tb/tb_sar_out_capture.sv
// Randomised and directed bench for sar_out_capture (AVG_LOG2=2 and 0 side by side).
// Behavioural queue model checked every cycle, plus hand-computed literal expectations.
module tb_sar_out_capture;

    localparam int S = 2;
    localparam int D = 4;

    logic       CLK;
    logic       RST_N;
    logic       EN;
    logic       CKO;
    logic [0:8] DATA;
    logic       OUT_READY;
    logic       CLR_OVF;

    logic [8:0] od0, od1;
    logic       v0, v1;
    logic [2:0] lv0, lv1;
    logic       ovf0, ovf1;
    logic [7:0] dc0, dc1;

    int n_tests = 0;
    int n_fail  = 0;

    sar_out_capture #(.AVG_LOG2(2), .FIFO_DEPTH(D), .SYNC_STAGES(S)) u0 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .CKO(CKO), .DATA(DATA),
        .OUT_DATA(od0), .OUT_VALID(v0), .OUT_READY(OUT_READY),
        .LEVEL(lv0), .OVF(ovf0), .CLR_OVF(CLR_OVF), .DROP_CNT(dc0)
    );

    sar_out_capture #(.AVG_LOG2(0), .FIFO_DEPTH(D), .SYNC_STAGES(S)) u1 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .CKO(CKO), .DATA(DATA),
        .OUT_DATA(od1), .OUT_VALID(v1), .OUT_READY(OUT_READY),
        .LEVEL(lv1), .OVF(ovf1), .CLR_OVF(CLR_OVF), .DROP_CNT(dc1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int exp_drop(input int d);
`ifdef SAR_OUT_DROP_CNT_EN
        return d;
`else
        return 0;
`endif
    endfunction

    // Reference model: per-lane running sum, sample count and output queue.
    int acc [2];
    int cnt [2];
    int drp [2];
    bit ovf [2];
    int q0[$];
    int q1[$];
    bit h [S+1];
    int log0[$];
    int log1[$];

    function automatic int lane_n(input int ln);
        return (ln == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            acc[i] = 0;
            cnt[i] = 0;
            drp[i] = 0;
            ovf[i] = 0;
        end
        q0.delete();
        q1.delete();
        for (int i = 0; i <= S; i++) h[i] = 0;
    endtask

    task automatic step_lane(input int ln, input bit cap);
        int sz;
        int w;
        bit pop;
        bit push;
        bit dr;
        sz   = (ln == 0) ? q0.size() : q1.size();
        pop  = (sz > 0) && OUT_READY;
        push = 0;
        dr   = 0;
        w    = 0;
        if (!EN) begin
            acc[ln] = 0;
            cnt[ln] = 0;
        end else if (cap) begin
            acc[ln] += int'(DATA);
            cnt[ln]++;
            if (cnt[ln] == lane_n(ln)) begin
                w       = acc[ln] / lane_n(ln);
                push    = 1;
                acc[ln] = 0;
                cnt[ln] = 0;
            end
        end
        if (pop) begin
            if (ln == 0) void'(q0.pop_front());
            else         void'(q1.pop_front());
        end
        if (push) begin
            if (sz < D || pop) begin
                if (ln == 0) q0.push_back(w);
                else         q1.push_back(w);
            end else begin
                dr = 1;
            end
        end
        if (CLR_OVF) begin
            ovf[ln] = 0;
            drp[ln] = 0;
        end
        if (dr) begin
            ovf[ln] = 1;
            if (drp[ln] < 255) drp[ln]++;
        end
    endtask

    always @(posedge CLK) begin
        bit cap;
        if (!RST_N) begin
            model_reset();
        end else begin
            // A capture is a rising edge of CKO seen S samples back.
            cap = h[S-1] && !h[S] && EN;
            step_lane(0, cap);
            step_lane(1, cap);
            for (int i = S; i > 0; i--) h[i] = h[i-1];
            h[0] = CKO;
        end
    end

    always @(negedge CLK) begin
        #1;
        if (RST_N) begin
            check("valid0", int'(v0), int'(q0.size() != 0));
            check("valid1", int'(v1), int'(q1.size() != 0));
            check("level0", int'(lv0), q0.size());
            check("level1", int'(lv1), q1.size());
            check("ovf0", int'(ovf0), int'(ovf[0]));
            check("ovf1", int'(ovf1), int'(ovf[1]));
            check("drop0", int'(dc0), exp_drop(drp[0]));
            check("drop1", int'(dc1), exp_drop(drp[1]));
            if (q0.size() != 0) check("data0", int'(od0), q0[0]);
            if (q1.size() != 0) check("data1", int'(od1), q1[0]);
            if (v0 && OUT_READY) log0.push_back(int'(od0));
            if (v1 && OUT_READY) log1.push_back(int'(od1));
        end
    end

    task automatic pulse(input int v);
        DATA = 9'(v);
        CKO  = 1'b1;
        repeat (S+3) @(negedge CLK);
        CKO = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic drain(input int n);
        OUT_READY = 1'b1;
        repeat (n) @(negedge CLK);
        OUT_READY = 1'b0;
    endtask

    task automatic en_blip();
        EN = 1'b0;
        @(negedge CLK);
        EN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic rand_cycles(input int n);
        repeat (n) begin
            @(negedge CLK);
            OUT_READY = ($urandom % 3) != 0;
            CLR_OVF   = ($urandom % 50) == 0;
        end
    endtask

    initial begin
        RST_N = 1'b0; EN = 1'b0; CKO = 1'b0; DATA = '0;
        OUT_READY = 1'b0; CLR_OVF = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_level", int'(lv0), 0);
        check("rst_valid", int'(v0), 0);
        check("rst_data", int'(od0), 0);
        check("rst_ovf", int'(ovf0), 0);
        RST_N = 1'b1;
        @(negedge CLK);

        pulse(55);
        pulse(66);
        check("en0_nopush0", int'(lv0), 0);
        check("en0_nopush1", int'(lv1), 0);

        EN = 1'b1;
        @(negedge CLK);
        pulse(100);
        pulse(101);
        pulse(102);
        DATA = 9'd103;
        CKO  = 1'b1;
        repeat (S) @(negedge CLK);
        check("avg_not_yet", int'(v0), 0);
        @(negedge CLK);
        check("avg_valid", int'(v0), 1);
        check("avg_data", int'(od0), 101);
        check("avg_level", int'(lv0), 1);
        repeat (2) @(negedge CLK);
        CKO = 1'b0;
        repeat (2) @(negedge CLK);
        check("raw_level", int'(lv1), 4);
        check("raw_head", int'(od1), 100);
        drain(8);

        for (int i = 1; i <= 6; i++) pulse(i);
        check("ovf_level", int'(lv1), 4);
        check("ovf_flag", int'(ovf1), 1);
        check("ovf_drops", int'(dc1), exp_drop(2));
        log1.delete();
        drain(8);
        check("drain_n", log1.size(), 4);
        for (int i = 0; i < 4; i++)
            check("drain_val", (log1.size() > i) ? log1[i] : -1, i + 1);

        for (int i = 1; i <= 3; i++) pulse(i);
        check("pre_rst_level", int'(lv1), 3);
        RST_N = 1'b0;
        model_reset();
        #1;
        check("arst_level", int'(lv1), 0);
        check("arst_valid", int'(v1), 0);
        check("arst_ovf", int'(ovf1), 0);
        check("arst_data", int'(od1), 0);
        check("arst_drop", int'(dc1), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        pulse(511);
        check("max_raw", int'(od1), 511);
        drain(6);
        en_blip();

        for (int i = 10; i <= 13; i++) pulse(i);
        check("full_level", int'(lv1), 4);
        DATA = 9'd14;
        CKO  = 1'b1;
        repeat (S) @(negedge CLK);
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        check("pp_level", int'(lv1), 4);
        check("pp_ovf", int'(ovf1), 0);
        repeat (2) @(negedge CLK);
        CKO = 1'b0;
        repeat (2) @(negedge CLK);
        log1.delete();
        drain(8);
        check("pp_n", log1.size(), 4);
        check("pp_head", (log1.size() > 0) ? log1[0] : -1, 11);
        check("pp_tail", (log1.size() > 3) ? log1[3] : -1, 14);
        en_blip();

        for (int i = 20; i <= 24; i++) pulse(i);
        check("drop_pre", int'(dc1), exp_drop(1));
        DATA = 9'd25;
        CKO  = 1'b1;
        repeat (S) @(negedge CLK);
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        check("clr_drop_ovf", int'(ovf1), 1);
        check("clr_drop_cnt", int'(dc1), exp_drop(1));
        repeat (2) @(negedge CLK);
        CKO = 1'b0;
        repeat (2) @(negedge CLK);
        drain(8);
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        @(negedge CLK);
        check("clr_ovf", int'(ovf1), 0);

        OUT_READY = 1'b1;
        en_blip();
        log0.delete();
        pulse(200);
        pulse(200);
        en_blip();
        for (int i = 0; i < 4; i++) pulse(8);
        repeat (4) @(negedge CLK);
        check("endrop_n", log0.size(), 1);
        check("endrop_val", (log0.size() > 0) ? log0[0] : -1, 8);
        OUT_READY = 1'b0;

        EN   = 1'b0;
        DATA = 9'd77;
        CKO  = 1'b1;
        repeat (5) @(negedge CLK);
        EN = 1'b1;
        repeat (5) @(negedge CLK);
        CKO = 1'b0;
        repeat (3) @(negedge CLK);
        check("held_cko0", int'(lv0), 0);
        check("held_cko1", int'(lv1), 0);
        pulse(33);
        check("after_held", int'(od1), 33);
        check("after_held_lv", int'(lv1), 1);
        drain(4);

        for (int k = 0; k < 300; k++) begin
            if (($urandom % 10) == 0) begin
                EN = 1'b0;
                rand_cycles(1 + ($urandom % 2));
                EN = 1'b1;
            end
            DATA = (($urandom % 4) == 0) ? 9'h1FF : 9'($urandom);
            CKO  = 1'b1;
            rand_cycles(S + 3 + ($urandom % 3));
            CKO = 1'b0;
            rand_cycles(1 + ($urandom % 3));
        end
        CLR_OVF = 1'b0;
        drain(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_out_capture.md
Name: sar_out_capture

Overview:
- Downstream of the 9-bit SAR controller.
- Takes the conversion-done strobe CKO and the 9-bit result bus DATA from the SAR output latch, resynchronises the strobe into the system clock domain and captures each result.
- Averages 2^AVG_LOG2 consecutive results, then buffers the averages in a small FIFO with a valid/ready interface towards the digital back-end.

Parameters:
- AVG_LOG2, 2, log2 of samples per output word; legal 0..4 (0 = no averaging).
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flops in the CKO synchroniser; at least 2.

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  capture enable (same EN that drives the SAR).
- CKO  input  1  SAR conversion-done strobe; asynchronous to CLK.
- DATA  input  [0:8]  SAR result; DATA[0] is the MSB; stable while CKO is high.
- OUT_DATA  output  [8:0]  averaged result, bit 8 is the MSB.
- OUT_VALID  output  1  FIFO not empty.
- OUT_READY  input  1  consumer accepts OUT_DATA when OUT_VALID and OUT_READY are both high.
- LEVEL  output  [$clog2(FIFO_DEPTH):0]  FIFO occupancy.
- OVF  output  1  sticky overflow flag.
- CLR_OVF  input  1  clears OVF.
- DROP_CNT  output  [7:0]  dropped-word counter (see Optional Feature).

Behaviour:
- Reset (RST_N=0, asynchronous): all of the following are 0.
  - Synchroniser flops and the edge-detect history flop.
  - Accumulator and sample counter.
  - FIFO pointers; LEVEL=0, OUT_VALID=0, OUT_DATA=0.
  - OVF=0, DROP_CNT=0.
- Synchroniser: CKO passes through SYNC_STAGES flops. A history flop holds the previous last-stage value.
- CAP strobe: CAP = last_stage & ~history & EN. CAP is one cycle wide per CKO rising edge.
- Latency: a CKO rise before CLK edge n gives CAP high in cycle n+SYNC_STAGES-1.
- Sampling: DATA is sampled directly on the CAP cycle. The SAR holds DATA for at least SYNC_STAGES+2 CLK cycles after CKO rises.
- Accumulator: ACC width is 9+AVG_LOG2 bits, unsigned, and cannot overflow. Sample counter CNT width is AVG_LOG2 bits.
- On CAP with CNT != 2^AVG_LOG2-1:
  - ACC <= ACC + DATA.
  - CNT <= CNT + 1.
- On CAP with CNT == 2^AVG_LOG2-1 (always true when AVG_LOG2=0):
  - Result word = (ACC + DATA) >> AVG_LOG2, truncated toward zero.
  - The result word is pushed to the FIFO on the same edge.
  - ACC <= 0, CNT <= 0.
- FIFO:
  - OUT_DATA always shows the head entry. OUT_VALID = (LEVEL != 0), registered.
  - OUT_VALID rises the cycle after the push into an empty FIFO; there is no fall-through.
  - Pop happens when OUT_VALID & OUT_READY.
  - Push and pop in the same cycle: both are performed and LEVEL is unchanged. This holds even when the FIFO is full, because the pop frees a slot.
  - Push while full with no pop: the new word is dropped, the FIFO is unchanged, and OVF <= 1.
  - Pop while empty: ignored.
  - While OUT_VALID=1 and OUT_READY=0, OUT_DATA holds its value.
- OVF: cleared by CLR_OVF. If CLR_OVF and a drop occur in the same cycle, the set wins.
- EN low:
  - CAP is suppressed, and ACC and CNT are cleared synchronously.
  - FIFO contents and the output handshake continue to work normally.
  - Synchroniser and history flops keep running, so re-enabling while CKO is already high does not create a spurious CAP.
- Mid-burst EN drop: the partial average is discarded. After re-enable, averaging restarts at CNT=0.

Optional Feature:
- Macro: SAR_OUT_DROP_CNT_EN.
- Defined: DROP_CNT is an 8-bit counter that increments on every dropped word and saturates at 255. CLR_OVF also clears it; on a simultaneous drop and clear, DROP_CNT becomes 1.
- Undefined: the DROP_CNT port remains, tied to 0, with no counter logic.

Decomposition:
- Package sar_out_pkg holds:
  - SAR_DATA_W = 9.
  - DROP_CNT_W = 8.
  - A typedef for the 9-bit sample word.
- Sub-module sar_out_fifo: synchronous FIFO parameterised by width and depth. Ports: push, pop, data in, data out, level, full, empty.
- The synchroniser, edge detect and accumulator stay in the top level.

Test Plan:
- Reset and idle: assert RST_N=0 mid-operation with LEVEL=3 -> next cycle LEVEL=0, OUT_VALID=0, OVF=0, OUT_DATA=0. CKO toggling while EN=0 -> no push.
- Averaging with AVG_LOG2=2: four CKO pulses with DATA=100, 101, 102, 103 -> exactly one word, OUT_DATA=101, valid SYNC_STAGES+1 cycles after the 4th CKO rise. With AVG_LOG2=0, DATA=511 -> OUT_DATA=511.
- Backpressure and overflow: AVG_LOG2=0, OUT_READY=0, six samples 1..6 with FIFO_DEPTH=4 -> LEVEL=4, OVF=1, DROP_CNT=2 (macro on), and draining yields 1, 2, 3, 4.
- Push and pop on full: FIFO full, OUT_READY=1 in the CAP cycle -> LEVEL stays 4, OVF stays 0, and the new word lands at the tail.
- EN drop mid-average: two samples of 200, EN low for 1 cycle, then four samples of 8 -> single output 8; no word contains 200.
- Edge cases:
  - CKO held high across an EN 0->1 transition -> no capture until the next CKO rise.
  - CLR_OVF in the same cycle as a drop -> OVF=1, DROP_CNT=1.
